frame_seq_ctrl: RTL and testbench
=================================

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 SHALL have parameter FRAME_MAX, default 8, meaning the maximum frame length in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cfg_we, input, 1 bit: config write strobe.
REQ-005 SHALL have port cfg_pattern, input, FRAME_MAX bits: reference pattern, right-aligned.
REQ-006 SHALL have port cfg_len, input, 4 bits: frame length in bits; legal range 3..FRAME_MAX.
REQ-007 SHALL have port cfg_frames, input, 8 bits: number of frames per run; 0 means continuous.
REQ-008 SHALL have port start, input, 1 bit: run request, level-sampled.
REQ-009 SHALL have port abort, input, 1 bit: terminate the run.
REQ-010 SHALL have port data_in, input, 1 bit: serial data bit.
REQ-011 SHALL have port data_valid, input, 1 bit: data_in is qualified this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high while a run is active.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at normal run completion.
REQ-014 SHALL have port match, output, 1 bit: one-cycle pulse when a frame equals the pattern.
REQ-015 SHALL have port not_match, output, 1 bit: one-cycle pulse when a frame differs from the pattern.
REQ-016 SHALL have port match_cnt, output, 8 bits: count of matching frames in the current or last run.
REQ-017 SHALL have port miss_cnt, output, 8 bits: count of mismatching frames in the current or last run.
REQ-018 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-019 SHALL implement FSM states IDLE and RUN; all outputs SHALL be registered.
REQ-020 SHALL latch cfg_pattern, cfg_len and cfg_frames on cfg_we in IDLE, and SHALL ignore cfg_we in RUN.
REQ-021 SHALL, on start in IDLE with a legal cfg_len, enter RUN, clear match_cnt, miss_cnt, bit index and frame count, and assert busy from the next cycle.
REQ-022 SHALL, when start and cfg_we occur in the same IDLE cycle, write the configuration and run with the pre-write configuration for that run.
REQ-023 SHALL, on start with cfg_len <3 or >FRAME_MAX, stay in IDLE, pulse cfg_err for one cycle, and leave the counters unchanged.
REQ-024 SHALL ignore start while in RUN.
REQ-025 SHALL, in RUN, sample data_in only on edges where data_valid=1; the first bit of each frame SHALL be compared with pattern[cfg_len-1], MSB-first; data_valid=0 SHALL hold the bit index.
REQ-026 SHALL evaluate the frame on the edge that samples its cfg_len-th bit, and assert exactly one of match or not_match for the following cycle only (latency 1), with no gap needed between frames.
REQ-027 SHALL update match_cnt or miss_cnt on the same edge as the verdict pulse, saturating at 255.
REQ-028 SHALL, on the verdict edge of frame number cfg_frames (cfg_frames≠0), return to IDLE, pulse done in the same cycle as the final verdict, and drive busy=0 in that cycle.
REQ-029 SHALL, with cfg_frames=0, run until abort; the frame counter SHALL wrap without effect.
REQ-030 SHALL, on abort in RUN (priority over data), return to IDLE at that edge, discard any partial frame, emit no verdict and no done, and retain the counters; abort in IDLE SHALL have no effect.
REQ-031 SHALL give abort priority when abort coincides with a frame's last bit, so that no verdict is produced.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, take effect at that edge with priority over all inputs, including mid-run.
REQ-033 SHALL reset to: state IDLE; busy, done, match, not_match and cfg_err = 0; match_cnt and miss_cnt = 0; bit index and frame count = 0.
REQ-034 SHALL reset the configuration to pattern 8'h1C (bits 011100), cfg_len 6, cfg_frames 1.

Verification
REQ-035 SHALL verify that after reset, start, then data 0,1,1,1,0,0 with valid on every cycle gives match=1 and done=1 in the cycle after the 6th bit, busy=0, match_cnt=1, miss_cnt=0.
REQ-036 SHALL verify that cfg pattern 4'b1011, len 4, frames 3, with stream 1011 0000 1011 gives pulses match, not_match, match; done with the third pulse; match_cnt=2, miss_cnt=1.
REQ-037 SHALL verify that default config with data_valid low on alternate cycles still produces a single match, one cycle after the 6th valid bit.
REQ-038 SHALL verify that abort after 3 bits of frame 2 gives busy=0 on the next cycle, no match, not_match or done, and the counters hold the frame-1 values.
REQ-039 SHALL verify that cfg_len=2 then start gives a one-cycle cfg_err pulse while busy stays 0; cfg_len=9 gives the same result.
REQ-040 SHALL verify that rst asserted mid-frame gives all outputs 0 and the default config on the next cycle, and that a subsequent start followed by 011100 gives match.

Source files
------------

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl
// Serial frame comparator. A run is started with `start` and then compares
// frames of cfg_len bits, taken MSB-first from `data_in` on cycles where
// `data_valid` is high, against the low cfg_len bits of the reference
// pattern. Each frame produces exactly one match or not_match pulse.
// A run ends after cfg_frames frames (or only on abort when cfg_frames = 0).
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   cfg_we       : configuration write strobe (honoured in IDLE only)
//   cfg_pattern  : reference pattern, right-aligned
//   cfg_len      : frame length in bits, legal range 3..FRAME_MAX
//   cfg_frames   : frames per run, 0 = continuous
//   start        : run request (level-sampled in IDLE)
//   abort        : terminate the active run, no verdict for a partial frame
//   data_in      : serial data bit
//   data_valid   : data_in qualifier
//   busy         : run active
//   done         : one-cycle pulse on normal run completion
//   match        : one-cycle pulse, frame equals the pattern
//   not_match    : one-cycle pulse, frame differs from the pattern
//   match_cnt    : matching frames in the current/last run (saturating)
//   miss_cnt     : mismatching frames in the current/last run (saturating)
//   cfg_err      : one-cycle pulse when start is rejected for a bad cfg_len
module frame_seq_ctrl #(
    parameter int FRAME_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [FRAME_MAX-1:0] cfg_pattern,
    input  logic [3:0]           cfg_len,
    input  logic [7:0]           cfg_frames,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 data_in,
    input  logic                 data_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic                 not_match,
    output logic [7:0]           match_cnt,
    output logic [7:0]           miss_cnt,
    output logic                 cfg_err
);

    localparam logic [0:0]           ST_IDLE = 1'b0;
    localparam logic [0:0]           ST_RUN  = 1'b1;
    localparam logic [FRAME_MAX-1:0] PAT_RST = FRAME_MAX'(8'h1C);
    localparam logic [FRAME_MAX-1:0] PAT_ONE = FRAME_MAX'(1'b1);
    localparam logic [3:0]           LEN_MAX = 4'(FRAME_MAX);

    // Saturating 8-bit increment used by both frame counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [0:0]           state_q,      state_d;
    // Programmed configuration (written in IDLE).
    logic [FRAME_MAX-1:0] cfg_pat_q,    cfg_pat_d;
    logic [3:0]           cfg_len_q,    cfg_len_d;
    logic [7:0]           cfg_frames_q, cfg_frames_d;
    // Snapshot used by the active run, so a write coinciding with start
    // only affects the next run.
    logic [FRAME_MAX-1:0] run_pat_q,    run_pat_d;
    logic [3:0]           run_len_q,    run_len_d;
    logic [7:0]           run_frames_q, run_frames_d;
    logic [3:0]           bit_idx_q,    bit_idx_d;
    logic [7:0]           frame_cnt_q,  frame_cnt_d;
    logic                 err_q,        err_d;       // mismatch seen so far in frame
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 match_q,      match_d;
    logic                 not_match_q,  not_match_d;
    logic                 cfg_err_q,    cfg_err_d;
    logic [7:0]           match_cnt_q,  match_cnt_d;
    logic [7:0]           miss_cnt_q,   miss_cnt_d;

    logic                 len_ok_s;
    logic [3:0]           pos_s;
    logic                 exp_bit_s;
    logic                 frame_bad_s;
    logic                 last_bit_s;
    logic [7:0]           frame_next_s;
    logic                 run_end_s;

    // Bit-level comparison helpers: the k-th bit of a frame is checked
    // against pattern[len-1-k].
    always_comb begin
        len_ok_s     = (cfg_len_q >= 4'd3) && (cfg_len_q <= LEN_MAX);
        pos_s        = run_len_q - 4'd1 - bit_idx_q;
        exp_bit_s    = |(run_pat_q & (PAT_ONE << pos_s));
        frame_bad_s  = err_q | (data_in ^ exp_bit_s);
        last_bit_s   = (bit_idx_q == (run_len_q - 4'd1));
        frame_next_s = frame_cnt_q + 8'd1;
        run_end_s    = (run_frames_q != 8'd0) && (frame_next_s == run_frames_q);
    end

    // Next-state logic for the controller, configuration and counters.
    always_comb begin
        state_d      = state_q;
        cfg_pat_d    = cfg_pat_q;
        cfg_len_d    = cfg_len_q;
        cfg_frames_d = cfg_frames_q;
        run_pat_d    = run_pat_q;
        run_len_d    = run_len_q;
        run_frames_d = run_frames_q;
        bit_idx_d    = bit_idx_q;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        busy_d       = busy_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        done_d       = 1'b0;
        match_d      = 1'b0;
        not_match_d  = 1'b0;
        cfg_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    cfg_pat_d    = cfg_pattern;
                    cfg_len_d    = cfg_len;
                    cfg_frames_d = cfg_frames;
                end else begin
                    cfg_pat_d    = cfg_pat_q;
                end
                if (start) begin
                    if (len_ok_s) begin
                        state_d      = ST_RUN;
                        busy_d       = 1'b1;
                        run_pat_d    = cfg_pat_q;
                        run_len_d    = cfg_len_q;
                        run_frames_d = cfg_frames_q;
                        bit_idx_d    = 4'd0;
                        frame_cnt_d  = 8'd0;
                        err_d        = 1'b0;
                        match_cnt_d  = 8'd0;
                        miss_cnt_d   = 8'd0;
                    end else begin
                        cfg_err_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort wins over data, including a frame's final bit.
                if (abort) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    bit_idx_d = 4'd0;
                    err_d     = 1'b0;
                end else if (data_valid) begin
                    if (last_bit_s) begin
                        bit_idx_d   = 4'd0;
                        err_d       = 1'b0;
                        frame_cnt_d = frame_next_s;
                        if (frame_bad_s) begin
                            not_match_d = 1'b1;
                            miss_cnt_d  = sat_inc(miss_cnt_q);
                        end else begin
                            match_d     = 1'b1;
                            match_cnt_d = sat_inc(match_cnt_q);
                        end
                        if (run_end_s) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        err_d     = frame_bad_s;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cfg_pat_q    <= PAT_RST;
            cfg_len_q    <= 4'd6;
            cfg_frames_q <= 8'd1;
            run_pat_q    <= PAT_RST;
            run_len_q    <= 4'd6;
            run_frames_q <= 8'd1;
            bit_idx_q    <= 4'd0;
            frame_cnt_q  <= 8'd0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            not_match_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            match_cnt_q  <= 8'd0;
            miss_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cfg_pat_q    <= cfg_pat_d;
            cfg_len_q    <= cfg_len_d;
            cfg_frames_q <= cfg_frames_d;
            run_pat_q    <= run_pat_d;
            run_len_q    <= run_len_d;
            run_frames_q <= run_frames_d;
            bit_idx_q    <= bit_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            match_q      <= match_d;
            not_match_q  <= not_match_d;
            cfg_err_q    <= cfg_err_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign match     = match_q;
    assign not_match = not_match_q;
    assign match_cnt = match_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Testbench for frame_seq_ctrl: directed scenarios plus randomized runs.
// Expected pulses are pushed into a scoreboard queue with the cycle in
// which they must appear; a separate monitor compares every output pulse.
module tb_frame_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, cfg_we, start, abort, data_in, data_valid;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_frames;
    logic       busy, done, match, not_match, cfg_err;
    logic [7:0] match_cnt, miss_cnt;

    always #5 clk = ~clk;

    frame_seq_ctrl #(.FRAME_MAX(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_frames(cfg_frames), .start(start),
        .abort(abort), .data_in(data_in), .data_valid(data_valid),
        .busy(busy), .done(done), .match(match), .not_match(not_match),
        .match_cnt(match_cnt), .miss_cnt(miss_cnt), .cfg_err(cfg_err)
    );

    typedef struct {
        int cyc;
        bit m, nm, d, ce, b;
        int mc, xc;
    } ev_t;

    ev_t exq[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;

    // Reference model state: programmed config, run snapshot, frame assembly.
    int  m_pat, m_len, m_frames;
    bit  m_run;
    int  r_pat, r_len, r_frames;
    int  m_mc, m_xc;
    int  fv, fn, fcnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit m, input bit nm, input bit d, input bit ce, input bit b);
        ev_t e;
        e.cyc = cyc + 1;
        e.m = m; e.nm = nm; e.d = d; e.ce = ce; e.b = b;
        e.mc = m_mc; e.xc = m_xc;
        exq.push_back(e);
    endtask

    // Monitor: every cycle, compare presented pulses against the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exq.size() > 0 && exq[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missing_event: expected at cycle %0d, now %0d", exq[0].cyc, cyc);
                void'(exq.pop_front());
            end
            if (exq.size() > 0 && exq[0].cyc == cyc) begin
                e = exq.pop_front();
                tests++;
                if ({match, not_match, done, cfg_err, busy} != {e.m, e.nm, e.d, e.ce, e.b}
                    || int'(match_cnt) != e.mc || int'(miss_cnt) != e.xc) begin
                    fails++;
                    $display("FAIL event@%0d: got m/nm/d/ce/b=%b%b%b%b%b mc=%0d xc=%0d expected %b%b%b%b%b mc=%0d xc=%0d",
                             cyc, match, not_match, done, cfg_err, busy, match_cnt, miss_cnt,
                             e.m, e.nm, e.d, e.ce, e.b, e.mc, e.xc);
                end
            end else if (match || not_match || done || cfg_err) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse@%0d: got m/nm/d/ce=%b%b%b%b expected 0000",
                         cyc, match, not_match, done, cfg_err);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_idle();
        cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
        data_valid = 1'b0; data_in = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        step();
        rst = 1'b0;
        m_run = 0; m_pat = 8'h1C; m_len = 6; m_frames = 1;
        m_mc = 0; m_xc = 0; fv = 0; fn = 0; fcnt = 0;
        check("reset_outputs", int'({busy, done, match, not_match, cfg_err, match_cnt, miss_cnt}), 0);
    endtask

    task automatic do_cfg(input int pat, input int len, input int frames);
        cfg_we = 1'b1;
        cfg_pattern = 8'(pat); cfg_len = 4'(len); cfg_frames = 8'(frames);
        if (!m_run) begin
            m_pat = pat & 255; m_len = len & 15; m_frames = frames & 255;
        end
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input bit with_cfg, input int pat, input int len, input int frames);
        bit legal;
        start = 1'b1;
        cfg_we = with_cfg;
        if (with_cfg) begin
            cfg_pattern = 8'(pat); cfg_len = 4'(len); cfg_frames = 8'(frames);
        end
        legal = (m_len >= 3) && (m_len <= 8);
        if (legal) begin
            r_pat = m_pat; r_len = m_len; r_frames = m_frames;
            m_run = 1; m_mc = 0; m_xc = 0; fv = 0; fn = 0; fcnt = 0;
        end else begin
            push_ev(0, 0, 0, 1, 0);
        end
        if (with_cfg) begin
            m_pat = pat & 255; m_len = len & 15; m_frames = frames & 255;
        end
        step();
        start = 1'b0;
        cfg_we = 1'b0;
        if (legal) begin
            check("busy_after_start", int'(busy), 1);
            check("cnt_clear_at_start", int'(match_cnt) + int'(miss_cnt), 0);
        end else begin
            check("busy_on_cfg_err", int'(busy), 0);
        end
    endtask

    // One qualified bit, preceded by gmin..gmax unqualified cycles; while a run
    // is active the gap cycles also carry start/cfg_we noise that must be ignored.
    task automatic send_bit(input bit b, input bit ab, input int gmin, input int gmax);
        int  g;
        bit  eq, dn;
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
            data_valid = 1'b0;
            data_in = 1'($urandom);
            abort = 1'b0;
            if (m_run && $urandom_range(3, 0) == 0) begin
                start = 1'b1; cfg_we = 1'b1;
                cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_frames = 8'($urandom);
            end
            step();
            start = 1'b0;
            cfg_we = 1'b0;
        end
        data_valid = 1'b1;
        data_in = b;
        abort = ab;
        if (m_run) begin
            if (ab) begin
                m_run = 0;
            end else begin
                fv = fv * 2 + int'(b);
                fn++;
                if (fn == r_len) begin
                    eq = (fv == (r_pat % (1 << r_len)));
                    fcnt++;
                    if (eq) m_mc = (m_mc < 255) ? m_mc + 1 : 255;
                    else    m_xc = (m_xc < 255) ? m_xc + 1 : 255;
                    dn = (r_frames != 0) && (fcnt == r_frames);
                    push_ev(eq, !eq, dn, 0, !dn);
                    if (dn) m_run = 0;
                    fv = 0;
                    fn = 0;
                end
            end
        end
        step();
        data_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_word(input int w, input int n, input bit ab_last, input int gmin, input int gmax);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(1'((w >> i) & 1), ab_last && (i == 0), gmin, gmax);
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        data_valid = 1'b0;
        m_run = 0;
        step();
        abort = 1'b0;
        check("busy_after_abort", int'(busy), 0);
        check("match_cnt_hold", int'(match_cnt), m_mc);
        check("miss_cnt_hold", int'(miss_cnt), m_xc);
    endtask

    initial begin
        int pat, len, frames, nf, w;
        rst = 1'b1;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_frames = 8'd0;
        drive_idle();
        step();
        do_reset();

        // Default configuration, continuous valid data.
        do_start(0, 0, 0, 0);
        send_word(6'b011100, 6, 0, 0, 0);
        check("default_busy_end", int'(busy), 0);
        check("default_match_cnt", int'(match_cnt), 1);
        check("default_miss_cnt", int'(miss_cnt), 0);

        // Three back-to-back frames: match, mismatch, match.
        do_cfg(8'h0B, 4, 3);
        do_start(0, 0, 0, 0);
        send_word(4'b1011, 4, 0, 0, 0);
        send_word(4'b0000, 4, 0, 0, 0);
        send_word(4'b1011, 4, 0, 0, 0);
        check("three_match_cnt", int'(match_cnt), 2);
        check("three_miss_cnt", int'(miss_cnt), 1);

        // Valid low on alternate cycles.
        do_cfg(8'h1C, 6, 1);
        do_start(0, 0, 0, 0);
        send_word(6'b011100, 6, 0, 1, 1);
        check("gapped_match_cnt", int'(match_cnt), 1);

        // Abort three bits into frame 2.
        do_cfg(8'h1C, 6, 2);
        do_start(0, 0, 0, 0);
        send_word(6'b011100, 6, 0, 0, 0);
        send_word(3'b011, 3, 0, 0, 0);
        do_abort();

        // Abort coinciding with the final bit of frame 2.
        do_start(0, 0, 0, 0);
        send_word(6'b111111, 6, 0, 0, 0);
        send_word(6'b011100, 6, 1, 0, 0);
        step();
        check("abort_last_busy", int'(busy), 0);
        check("abort_last_match_cnt", int'(match_cnt), 0);
        check("abort_last_miss_cnt", int'(miss_cnt), 1);

        // Illegal lengths are rejected.
        do_cfg(8'h1C, 2, 1);
        do_start(0, 0, 0, 0);
        do_cfg(8'h1C, 9, 1);
        do_start(0, 0, 0, 0);

        // Config write together with start: run uses the old config.
        do_cfg(8'h0B, 4, 1);
        do_start(1, 8'h1C, 6, 1);
        send_word(4'b1011, 4, 0, 0, 0);
        do_start(0, 0, 0, 0);
        send_word(6'b011100, 6, 0, 0, 0);

        // Reset mid-frame restores defaults.
        do_cfg(8'h0B, 4, 5);
        do_start(0, 0, 0, 0);
        send_word(2'b10, 2, 0, 0, 0);
        do_reset();
        do_start(0, 0, 0, 0);
        send_word(6'b011100, 6, 0, 0, 0);

        // Continuous run saturates match_cnt.
        do_cfg(8'h05, 3, 0);
        do_start(0, 0, 0, 0);
        repeat (258) send_word(3'b101, 3, 0, 0, 0);
        do_abort();
        check("saturated_match_cnt", int'(match_cnt), 255);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            pat = $urandom_range(255, 0);
            len = $urandom_range(9, 2);
            frames = $urandom_range(4, 0);
            do_cfg(pat, len, frames);
            do_start(0, 0, 0, 0);
            if (m_run) begin
                nf = (frames == 0) ? 3 : frames;
                for (int f = 0; f < nf; f++) begin
                    w = ($urandom_range(1, 0) == 1) ? pat : int'($urandom_range(255, 0));
                    send_word(w, len, 0, 0, 2);
                end
                if (frames == 0) begin
                    do_abort();
                end else begin
                    send_word(int'($urandom_range(7, 0)), 3, 0, 0, 1);
                end
            end
        end

        repeat (3) step();
        check("scoreboard_empty", exq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
